mon_frame_sender: RTL and testbench

Transmit side of the monitor serial link: serialises 40-bit frames onto from_mon, clocked by mon_clk. It is the counterpart of the existing frame receiver on to_mon. Upstream logic pushes frames through a valid/ready port into a small FIFO. A shift engine emits each frame with start-bit framing and an enforced inter-frame idle gap.

---
 rtl/mon_pkg.sv | 17 +
 rtl/mon_frame_fifo.sv | 53 +++++
 rtl/mon_frame_sender.sv | 159 +++++++++++++++
 tb/tb_mon_frame_sender.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared constants and types for the monitor serial link (sender and receiver).
package mon_pkg;

    localparam int   FRAME_W    = 40;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam int   IDX_W      = $clog2(FRAME_W);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_GAP
    } tx_state_e;

endpackage

// File: rtl/mon_frame_fifo.sv
// Frame buffer for the monitor link sender: FRAME_W x DEPTH synchronous FIFO.
module mon_frame_fifo
    import mon_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [FRAME_W-1:0]     data_i,
    input  logic                   pop_i,
    output logic [FRAME_W-1:0]     data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_q;
    logic [AW-1:0]      rd_q;
    logic [AW:0]        level_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

endmodule

// File: rtl/mon_frame_sender.sv
// Monitor link transmitter: FIFO-buffered 40-bit frames, start bit, idle gap.
// Define MON_FRAME_PARITY_EN to append an even-parity bit after the data.
module mon_frame_sender
    import mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 2,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                        mon_clk,
    input  logic                        reset_n,
    input  logic [FRAME_W-1:0]          in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        from_mon,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] GAP_LAST = IDX_W'(GAP_BITS - 1);

    tx_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               line_q, line_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef MON_FRAME_PARITY_EN
    logic               par_q, par_d;
`endif

    logic               fifo_full;
    logic               fifo_empty;
    logic [FRAME_W-1:0] fifo_head;
    logic               push;
    logic               pop;
    logic               bit_end;

    assign in_ready = reset_n && !fifo_full;
    assign push     = in_valid && in_ready;
    assign bit_end  = (cnt_q == CNT_LAST);

    mon_frame_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (mon_clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .data_i  (in_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Line/busy/done are derived from the current state and registered,
    // so the wire trails the state machine by one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
`ifdef MON_FRAME_PARITY_EN
        par_d   = par_q;
`endif
        line_d  = LINE_IDLE;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (state_q != TX_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            TX_IDLE: begin
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head;
`ifdef MON_FRAME_PARITY_EN
                    par_d   = ^fifo_head;
`endif
                    state_d = TX_START;
                end
            end
            TX_START: begin
                line_d = LINE_START;
                if (bit_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                line_d = shreg_q[FRAME_W-1];
                if (bit_end) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == BIT_LAST) begin
                        idx_d = '0;
`ifdef MON_FRAME_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_GAP;
`endif
                    end
                end
            end
`ifdef MON_FRAME_PARITY_EN
            TX_PARITY: begin
                line_d = par_q;
                if (bit_end) state_d = TX_GAP;
            end
`endif
            TX_GAP: begin
                if (bit_end) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == GAP_LAST) begin
                        done_d  = 1'b1;
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge mon_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            line_q  <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MON_FRAME_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MON_FRAME_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign from_mon = line_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_mon_frame_sender.sv
// Bench for mon_frame_sender: default instance plus a CLKS_PER_BIT=4 instance.
`timescale 1ns/1ps
module tb_mon_frame_sender;

    localparam int GAPB = 2;
`ifdef MON_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = 1 + 40 + PB + GAPB;
    localparam int CPB1  = 4;
    localparam int LEN1  = FRAME * CPB1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst0_n, in_valid0, in_ready0, from_mon0, busy0, tx_done0;
    logic [39:0] in_data0;
    logic [1:0]  level0;
    logic        rst1_n, in_valid1, in_ready1, from_mon1, busy1, tx_done1;
    logic [39:0] in_data1;
    logic [1:0]  level1;

    mon_frame_sender dut0 (
        .mon_clk    (clk),
        .reset_n    (rst0_n),
        .in_data    (in_data0),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .from_mon   (from_mon0),
        .busy       (busy0),
        .tx_done    (tx_done0),
        .fifo_level (level0)
    );

    mon_frame_sender #(.CLKS_PER_BIT(CPB1)) dut1 (
        .mon_clk    (clk),
        .reset_n    (rst1_n),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .from_mon   (from_mon1),
        .busy       (busy1),
        .tx_done    (tx_done1),
        .fifo_level (level1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Receiver-side view of dut0's wire: one record per decoded frame.
    typedef struct {
        logic [39:0] data;
        logic        par;
        int          start;
        int          done;
        bit          gap_ok;
        bit          done_ok;
        bit          idle_ok;
    } rx_t;
    rx_t rxq[$];

    int maxlvl = 0;
    always @(negedge clk) if (int'(level0) > maxlvl) maxlvl = int'(level0);

    initial begin : mon0
        rx_t r;
        forever begin
            @(negedge clk);
            if (rst0_n === 1'b1 && from_mon0 === 1'b0) begin
                r.start   = cyc;
                r.gap_ok  = 1'b1;
                r.done_ok = (tx_done0 === 1'b0) && (busy0 === 1'b1);
                r.par     = 1'b0;
                r.done    = -1;
                for (int i = 39; i >= 0; i--) begin
                    @(negedge clk);
                    r.data[i] = from_mon0;
                    if (tx_done0 !== 1'b0) r.done_ok = 1'b0;
                end
`ifdef MON_FRAME_PARITY_EN
                @(negedge clk);
                r.par = from_mon0;
`endif
                for (int g = 0; g < GAPB; g++) begin
                    @(negedge clk);
                    if (from_mon0 !== 1'b1 || busy0 !== 1'b1) r.gap_ok = 1'b0;
                    if (tx_done0 === 1'b1) begin
                        if (r.done < 0) r.done = cyc;
                        else r.done_ok = 1'b0;
                    end else if (tx_done0 !== 1'b0) r.done_ok = 1'b0;
                end
                @(negedge clk);
                r.idle_ok = (from_mon0 === 1'b1) && (busy0 === 1'b0)
                            && (tx_done0 === 1'b0);
                rxq.push_back(r);
            end
        end
    end

    task automatic push0(input logic [39:0] d, output int acc);
        int t = 0;
        in_data0  = d;
        in_valid0 = 1'b1;
        while (in_ready0 !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("push0_timeout", 64'(t), 64'd0);
        @(posedge clk);
        @(negedge clk);
        acc       = cyc;
        in_valid0 = 1'b0;
    endtask

    task automatic push1(input logic [39:0] d);
        int t = 0;
        in_data1  = d;
        in_valid1 = 1'b1;
        while (in_ready1 !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("push1_timeout", 64'(t), 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rxq.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("rx_timeout", 64'(rxq.size()), 64'(n));
    endtask

    task automatic wait_low1();
        int t = 0;
        while (from_mon1 !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("start1_timeout", 64'(t), 64'd0);
    endtask

    task automatic chk_frame(input string nm, input rx_t r,
                             input logic [39:0] d);
        chk({nm, "_data"}, 64'(r.data), 64'(d));
        chk({nm, "_done_off"}, 64'(r.done - r.start + 1), 64'(FRAME));
        chk({nm, "_framing"}, 64'({r.gap_ok, r.done_ok, r.idle_ok}), 64'd7);
    endtask

    typedef struct {
        logic [39:0] data;
        logic        par;
    } vec_t;
    vec_t tbl[6];

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rx_t         r;
        int          acc;
        int          accs[4];
        int          prev;
        logic [39:0] d;
        logic [63:0] w;
        logic [39:0] expq[$];
        logic        eb[$];
        logic        cap[LEN1];
        logic        dn[LEN1];
        int          mism, dmis, zeros, viol;

        tbl[0] = '{40'hA5_0F_00_FF_3C, 1'b0};
        tbl[1] = '{40'hFF_FFFF_FFFF, 1'b0};
        tbl[2] = '{40'h00_0000_0001, 1'b1};
        tbl[3] = '{40'h80_0000_0001, 1'b0};
        tbl[4] = '{40'h12_3456_789A, 1'b1};
        tbl[5] = '{40'h00_0000_0000, 1'b0};

        rst0_n = 1'b0; rst1_n = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_data0 = '0; in_data1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_from_mon", 64'(from_mon0), 64'd1);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_tx_done", 64'(tx_done0), 64'd0);
        chk("rst_level", 64'(level0), 64'd0);
        chk("rst_in_ready", 64'(in_ready0), 64'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready0), 64'd1);

        // Table of single frames: content, latency, parity, timing.
        for (int k = 0; k < 6; k++) begin
            push0(tbl[k].data, acc);
            wait_rx(1);
            r = rxq.pop_front();
            chk_frame($sformatf("tbl%0d", k), r, tbl[k].data);
            chk($sformatf("tbl%0d_latency", k), 64'(r.start - acc), 64'd2);
`ifdef MON_FRAME_PARITY_EN
            chk($sformatf("tbl%0d_parity", k), 64'(r.par), 64'(tbl[k].par));
`endif
        end

        // Back-to-back pushes on consecutive cycles.
        push0(40'h1, accs[0]);
        push0(40'h2, accs[1]);
        chk("b2b_push_adjacent", 64'(accs[1] - accs[0]), 64'd1);
        wait_rx(2);
        r = rxq.pop_front();
        chk_frame("b2b0", r, 40'h1);
        prev = r.start;
        r = rxq.pop_front();
        chk_frame("b2b1", r, 40'h2);
        chk("b2b_spacing", 64'(r.start - prev), 64'(FRAME + 1));

        // Backpressure with valid held: fourth frame waits for the pop.
        for (int k = 0; k < 4; k++) begin
            push0(40'(k + 1), accs[k]);
            if (k == 2) begin
                chk("bp_ready_low", 64'(in_ready0), 64'd0);
                chk("bp_level_full", 64'(level0), 64'd2);
            end
        end
        chk("bp_acc12", 64'(accs[1] - accs[0]), 64'd1);
        chk("bp_acc23", 64'(accs[2] - accs[1]), 64'd1);
        chk("bp_acc34", 64'(accs[3] - accs[2]), 64'(FRAME + 1));
        wait_rx(4);
        for (int k = 0; k < 4; k++) begin
            r = rxq.pop_front();
            chk($sformatf("bp_order%0d", k), 64'(r.data), 64'(k + 1));
        end

        // Random frames with random idle spacing against a frame queue.
        prev = 0;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 60)) @(negedge clk);
            w = {$urandom(), $urandom()};
            d = w[39:0];
            push0(d, acc);
            expq.push_back(d);
        end
        wait_rx(16);
        for (int k = 0; k < 16; k++) begin
            r = rxq.pop_front();
            d = expq.pop_front();
            chk_frame($sformatf("rnd%0d", k), r, d);
`ifdef MON_FRAME_PARITY_EN
            chk($sformatf("rnd%0d_parity", k), 64'(r.par), 64'(^d));
`endif
            if (k > 0)
                chk($sformatf("rnd%0d_spacing", k),
                    64'(r.start - prev >= FRAME + 1), 64'd1);
            prev = r.start;
        end
        chk("max_level", 64'(maxlvl), 64'd2);

        // Slow link: whole waveform against a bit-time expansion.
        d = 40'h80_0000_0001;
        push1(d);
        wait_low1();
        eb.push_back(1'b0);
        for (int b = 39; b >= 0; b--) eb.push_back(d[b]);
`ifdef MON_FRAME_PARITY_EN
        eb.push_back(^d);
`endif
        for (int g = 0; g < GAPB; g++) eb.push_back(1'b1);
        cap[0] = from_mon1;
        dn[0]  = tx_done1;
        for (int i = 1; i < LEN1; i++) begin
            @(negedge clk);
            cap[i] = from_mon1;
            dn[i]  = tx_done1;
        end
        mism = 0; dmis = 0; zeros = 0;
        for (int i = 0; i < LEN1; i++) begin
            if (cap[i] !== eb[i / CPB1]) mism++;
            if (dn[i] !== (i == LEN1 - 1)) dmis++;
            if (cap[i] === 1'b0) zeros++;
        end
        chk("cpb4_wave", 64'(mism), 64'd0);
        chk("cpb4_done_pos", 64'(dmis), 64'd0);
        chk("cpb4_low_cycles", 64'(zeros), 64'(156 + 4 * PB));
        @(negedge clk);
        chk("cpb4_busy_drop", 64'(busy1), 64'd0);

        // Reset in the middle of data bit 20 with a frame still queued.
        push1(40'h0);
        push1(40'h5);
        wait_low1();
        repeat (CPB1 + 20 * CPB1) @(negedge clk);
        chk("mid_line_pre", 64'(from_mon1), 64'd0);
        chk("mid_level_pre", 64'(level1), 64'd1);
        chk("mid_busy_pre", 64'(busy1), 64'd1);
        #2 rst1_n = 1'b0;
        #1;
        chk("mid_rst_line", 64'(from_mon1), 64'd1);
        chk("mid_rst_level", 64'(level1), 64'd0);
        chk("mid_rst_busy", 64'(busy1), 64'd0);
        chk("mid_rst_ready", 64'(in_ready1), 64'd0);
        @(negedge clk);
        rst1_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (from_mon1 !== 1'b1 || busy1 !== 1'b0) viol++;
        end
        chk("mid_post_idle", 64'(viol), 64'd0);
        chk("mid_post_ready", 64'(in_ready1), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
